// File: rtl/input_info_arbiter_if.sv
// Bundle between the per-port info FIFOs, the input info arbiter and its downstream enqueue logic.
// master = arbiter side, slave = FIFO/downstream side.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 16
`endif
`ifndef PRI_NUM
`define PRI_NUM 4
`endif
`ifndef DATABUF_HIGH_LIMIT_NUM
`define DATABUF_HIGH_LIMIT_NUM 256
`endif
`ifndef CRC32_LENGTH_WIDTH
`define CRC32_LENGTH_WIDTH 11
`endif

interface input_info_arbiter_if #(
    parameter int unsigned PORT_NUM = `PORT_NUB_TOTAL,
    parameter int unsigned INFO_BIT = $clog2(`PORT_NUB_TOTAL) + $clog2(`PRI_NUM)
                                    + $clog2(`DATABUF_HIGH_LIMIT_NUM) + `CRC32_LENGTH_WIDTH
);
    localparam int unsigned SRC_W = $clog2(PORT_NUM);

    logic [PORT_NUM-1:0]          fifo_empty;
    logic [PORT_NUM*INFO_BIT-1:0] fifo_rd_data;
    logic [PORT_NUM-1:0]          fifo_rd_en;
    logic                         out_valid;
    logic                         out_ready;
    logic [INFO_BIT-1:0]          out_info;
    logic [SRC_W-1:0]             out_src_port;

    modport master (
        input  fifo_empty, fifo_rd_data, out_ready,
        output fifo_rd_en, out_valid, out_info, out_src_port
    );

    modport slave (
        output fifo_empty, fifo_rd_data, out_ready,
        input  fifo_rd_en, out_valid, out_info, out_src_port
    );
endinterface

// File: rtl/input_info_arbiter.sv
// Round-robin arbiter popping one per-port info FIFO into a single registered output slot.
// Optional macro INFO_ARB_PRI_EN: arbitrate only among requesters carrying the highest head pri.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 16
`endif
`ifndef PRI_NUM
`define PRI_NUM 4
`endif
`ifndef DATABUF_HIGH_LIMIT_NUM
`define DATABUF_HIGH_LIMIT_NUM 256
`endif
`ifndef CRC32_LENGTH_WIDTH
`define CRC32_LENGTH_WIDTH 11
`endif

module input_info_arbiter #(
    parameter int unsigned PORT_NUM = `PORT_NUB_TOTAL,
    parameter int unsigned PRI_NUM  = `PRI_NUM,
    parameter int unsigned INFO_BIT = $clog2(`PORT_NUB_TOTAL) + $clog2(`PRI_NUM)
                                    + $clog2(`DATABUF_HIGH_LIMIT_NUM) + `CRC32_LENGTH_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input_info_arbiter_if.master bus
);
    localparam int unsigned SRC_W = $clog2(PORT_NUM);

    typedef enum logic [0:0] {IDLE, HOLD} state_e;

    state_e               state_q, state_d;
    logic                 out_valid_q, out_valid_d;
    logic [INFO_BIT-1:0]  out_info_q, out_info_d;
    logic [SRC_W-1:0]     out_src_q, out_src_d;
    logic [SRC_W-1:0]     last_grant_q, last_grant_d;
    logic [PORT_NUM-1:0]  req, elig;
    logic [SRC_W-1:0]     win;
    logic                 any_elig;
    logic                 load;
    logic [PORT_NUM-1:0]  rd_en_c;

    assign req = ~bus.fifo_empty;

`ifdef INFO_ARB_PRI_EN
    localparam int unsigned PRI_W   = $clog2(PRI_NUM);
    localparam int unsigned PRI_LSB = INFO_BIT - SRC_W - PRI_W;

    logic [PRI_W-1:0] pri_max;

    // Keep only requesters whose head pri equals the highest pending pri.
    always_comb begin
        pri_max = '0;
        for (int unsigned p = 0; p < PORT_NUM; p++) begin
            if (req[p] && (bus.fifo_rd_data[p*INFO_BIT+PRI_LSB +: PRI_W] > pri_max))
                pri_max = bus.fifo_rd_data[p*INFO_BIT+PRI_LSB +: PRI_W];
        end
        elig = '0;
        for (int unsigned p = 0; p < PORT_NUM; p++)
            elig[p] = req[p] && (bus.fifo_rd_data[p*INFO_BIT+PRI_LSB +: PRI_W] == pri_max);
    end
`else
    assign elig = req;
`endif

    // Descending offsets so the nearest port after last_grant wins; offset PORT_NUM revisits last_grant.
    always_comb begin
        int unsigned idx;
        idx      = 0;
        win      = last_grant_q;
        any_elig = 1'b0;
        for (int unsigned i = PORT_NUM; i >= 1; i--) begin
            idx = (32'(last_grant_q) + i) % PORT_NUM;
            if (elig[SRC_W'(idx)]) begin
                win      = SRC_W'(idx);
                any_elig = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_info_q   <= '0;
            out_src_q    <= '0;
            last_grant_q <= SRC_W'(PORT_NUM - 1);
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_info_q   <= out_info_d;
            out_src_q    <= out_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        out_info_d   = out_info_q;
        out_src_d    = out_src_q;
        last_grant_d = last_grant_q;
        load         = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    load    = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    if (any_elig) load = 1'b1;
                    else          state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            out_info_d   = bus.fifo_rd_data[32'(win)*INFO_BIT +: INFO_BIT];
            out_src_d    = win;
            last_grant_d = win;
        end
        out_valid_d = (state_d == HOLD);
        rd_en_c     = (load && !rst) ? (PORT_NUM'(1) << win) : '0;
    end

    assign bus.fifo_rd_en   = rd_en_c;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_info     = out_info_q;
    assign bus.out_src_port = out_src_q;
endmodule
